if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 The ports SHALL be, in order:
  clk  input  1  sole clock, rising edge
  rst  input  1  asynchronous active-high reset
  imem_req_valid  output  1  fetch request valid
  imem_req_ready  input  1  instruction memory accepts the request
  imem_req_addr  output  32  word-aligned fetch address
  imem_rsp_valid  input  1  response data valid; at most one response per accepted request
  imem_rsp_data  input  32  fetched instruction word
  redirect  input  1  branch/flush request from EX
  redirect_addr  input  32  new fetch address; bits [1:0] are ignored
  id_valid  output  1  id_params holds a valid instruction
  id_ready  input  1  ID/EX accepts the instruction
  id_params  output  id_params_t  {ir, ia_plus_4} to IF/ID
REQ-003 The parameter SHALL be: RESET_VECTOR, 32'h0000_0000, PC value after reset.

Function
REQ-004 The block SHALL hold a 32-bit PC, a 32-bit in-flight address register and a one-entry output register.
REQ-005 The FSM SHALL have three states: FETCH (may issue a request), WAIT (one request outstanding), DROP (one request outstanding whose response must be discarded).
REQ-006 In FETCH, imem_req_valid SHALL be 1 only when the output register is empty or is being consumed this cycle (id_valid & id_ready).
REQ-007 imem_req_addr SHALL equal {PC[31:2], 2'b00}.
REQ-008 On request acceptance (imem_req_valid & imem_req_ready), the block SHALL latch PC into the in-flight register, set PC to PC+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), and enter WAIT.
REQ-009 In WAIT, on imem_rsp_valid the block SHALL load ir=imem_rsp_data and ia_plus_4=in-flight+4, set id_valid=1 in the next cycle, and return to FETCH.
REQ-010 Fetch latency SHALL be one cycle from response to id_valid; with zero-wait memory, throughput SHALL be one instruction per two cycles.
REQ-011 id_valid and id_params SHALL stay stable while id_valid & !id_ready.
REQ-012 id_valid SHALL clear after id_valid & id_ready unless a new response loads in the same cycle.
REQ-013 imem_rsp_valid in FETCH SHALL be ignored.
REQ-014 redirect SHALL have priority over all other events: PC <= {redirect_addr[31:2], 2'b00}, and id_valid SHALL be 0 next cycle.
REQ-015 redirect in WAIT without imem_rsp_valid SHALL go to DROP.
REQ-016 redirect in WAIT with imem_rsp_valid in the same cycle SHALL discard that response and go to FETCH.
REQ-017 redirect in FETCH with the request accepted in the same cycle SHALL go to DROP, and PC SHALL take redirect_addr, not PC+4.
REQ-018 redirect in DROP SHALL update PC and remain in DROP.
REQ-019 In DROP, imem_rsp_valid SHALL be discarded and the FSM SHALL go to FETCH.
REQ-020 No request SHALL issue in WAIT or DROP.

Reset
REQ-021 While rst=1, the block SHALL hold PC=RESET_VECTOR, state=FETCH, id_valid=0, id_params=0, in-flight=0, imem_req_valid=0.
REQ-022 Reset asserted mid-request SHALL abandon the request; a response arriving after reset release in FETCH is ignored per REQ-013.
REQ-023 The first request SHALL be issued on the first rising edge after rst deasserts, at RESET_VECTOR.

Structure
REQ-024 RESET_VECTOR default and the if_state_e enum SHALL live in the shared types package, alongside the existing id_params_t and u32_t.
REQ-025 The output register SHALL be a sub-module if_id_buf (valid/ready, one entry, flush input); FSM and PC SHALL stay in if_stage.

Verification
REQ-026 The bench SHALL cover these scenarios:
  - Reset release, zero-wait memory, id_ready=1: addresses 0,4,8 on cycles 1,3,5; ia_plus_4 = 4,8,12.
  - id_ready=0 for 5 cycles with an instruction held: id_params stable, no new request, resumes after id_ready=1.
  - redirect to 32'h0000_1003 while in WAIT: the stale response is dropped, the next request addr is 32'h0000_1000, and the next ir is from 0x1000.
  - redirect coincident with imem_rsp_valid: that word is never presented, the next fetch is at redirect_addr.
  - PC=32'hFFFF_FFFC: the next request address wraps to 32'h0000_0000, with ia_plus_4=0 for that instruction.
  - rst asserted during WAIT: outputs clear immediately (asynchronously), and the post-reset fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared types for the instruction fetch stage
package if_stage_pkg;

   typedef logic [31:0] u32_t;

   typedef struct packed {
      u32_t ir;
      u32_t ia_plus_4;
   } id_params_t;

   typedef enum logic [1:0] {FETCH, WAIT, DROP} if_state_e;

   localparam u32_t RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/if_id_buf.sv
// if_id_buf: one-entry valid/ready output register between IF and ID with flush
module if_id_buf
   import if_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       in_valid,
   output logic       in_ready,
   input  id_params_t in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output id_params_t out_data
);

   assign in_ready = !out_valid || out_ready;

   // data is left in place on consume/flush so it only changes on a new load
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_valid) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end

endmodule

// File: rtl/if_stage.sv
// if_stage: fetch FSM and PC; issues one outstanding imem request and feeds IF/ID
module if_stage
   import if_stage_pkg::*;
#(
   parameter u32_t RESET_VECTOR = if_stage_pkg::RESET_VECTOR
) (
   input  logic       clk,
   input  logic       rst,
   output logic       imem_req_valid,
   input  logic       imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic       imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic       redirect,
   input  logic [31:0] redirect_addr,
   output logic       id_valid,
   input  logic       id_ready,
   output id_params_t id_params
);

   if_state_e  state, state_nx;
   u32_t       pc, pc_nx, inflight;
   logic       buf_ready, accept, load;
   id_params_t rsp_params;

   // requests are only offered when the output register will have room for the reply
   assign imem_req_valid = !rst && state == FETCH && buf_ready;
   assign imem_req_addr  = pc & ~32'd3;
   assign accept         = imem_req_valid && imem_req_ready;
   assign load           = state == WAIT && imem_rsp_valid && !redirect;
   assign rsp_params     = '{ir: imem_rsp_data, ia_plus_4: inflight + 32'd4};

   always_comb begin
      pc_nx    = redirect ? redirect_addr & ~32'd3 : accept ? pc + 32'd4 : pc;
      state_nx = state == FETCH  ? (accept ? (redirect ? DROP : WAIT) : FETCH)
               : imem_rsp_valid ? FETCH
               : redirect       ? DROP
               : state;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= FETCH;
         pc       <= RESET_VECTOR;
         inflight <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (accept) inflight <= pc;
      end

   if_id_buf u_buf (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .in_valid (load),
      .in_ready (buf_ready),
      .in_data  (rsp_params),
      .out_valid(id_valid),
      .out_ready(id_ready),
      .out_data (id_params)
   );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized fetch-stage bench with memory model and in-order scoreboard
module tb_if_stage;
   import if_stage_pkg::*;

   logic       clk = 1'b0, rst = 1'b1;
   logic       imem_req_valid, imem_req_ready = 1'b1, imem_rsp_valid = 1'b0;
   logic       redirect = 1'b0, id_valid, id_ready = 1'b1;
   u32_t       imem_req_addr, imem_rsp_data = '0, redirect_addr = '0;
   id_params_t id_params;

   int checks = 0, passes = 0;
   id_params_t sbq[$], hs_log[$];
   u32_t acc_addr[$];
   int   acc_cyc[$];
   u32_t exp_pc = RESET_VECTOR;
   int   cyc = 0, hs = 0;
   logic mem_pend = 1'b0, lat_rand = 1'b0;
   u32_t mem_addr = '0;
   int   mem_wait = 0, lat = 0;
   logic s_acc, s_rsp, s_redir, s_rst;
   u32_t s_addr, s_raddr;
   logic prev_hold = 1'b0;
   id_params_t prev_p;

   always #5 clk = ~clk;

   if_stage dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .id_valid      (id_valid),
      .id_ready      (id_ready),
      .id_params     (id_params)
   );

   function automatic u32_t mem_fn(u32_t a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // monitor: every ID handshake must match the oldest expected instruction
   always @(negedge clk) begin
      if (rst) prev_hold = 1'b0;
      else begin
         if (prev_hold) begin
            chk("hold_valid", 64'(id_valid), 64'd1);
            chk("hold_params", id_params, prev_p);
         end
         if (imem_req_valid) chk("req_while_full", 64'(id_valid & !id_ready), 64'd0);
         if (id_valid && id_ready) begin
            hs++;
            hs_log.push_back(id_params);
            chk("id_expected", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) chk("id_params", id_params, sbq.pop_front());
         end
         prev_hold = id_valid & !id_ready & !redirect;
         prev_p    = id_params;
      end
   end

   // one cycle: sample mid-cycle, then update reference model and memory after the edge
   task automatic tick();
      @(negedge clk);
      s_acc = imem_req_valid & imem_req_ready;
      s_addr = imem_req_addr;
      s_rsp = imem_rsp_valid;
      s_redir = redirect;
      s_raddr = redirect_addr;
      s_rst = rst;
      @(posedge clk);
      #1;
      if (!s_rst) begin
         if (s_acc) begin
            chk("req_addr", 64'(s_addr), 64'(exp_pc));
            acc_addr.push_back(s_addr);
            acc_cyc.push_back(cyc);
         end
         if (s_redir) begin
            sbq.delete();
            exp_pc = s_raddr & ~32'd3;
         end else if (s_acc) begin
            sbq.push_back('{ir: mem_fn(exp_pc), ia_plus_4: exp_pc + 32'd4});
            exp_pc += 32'd4;
         end
         if (s_rsp) mem_pend = 1'b0;
         if (s_acc) begin
            mem_pend = 1'b1;
            mem_addr = s_addr;
            mem_wait = lat_rand ? int'($urandom_range(3, 0)) : lat;
         end
      end
      cyc++;
      imem_rsp_valid = 1'b0;
      if (mem_pend) begin
         if (mem_wait == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_fn(mem_addr);
         end else mem_wait--;
      end
   endtask

   task automatic clear_logs();
      acc_addr.delete();
      acc_cyc.delete();
      hs_log.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_pend = 1'b0;
      sbq.delete();
      exp_pc = RESET_VECTOR;
      tick();
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_params", id_params, 64'd0);
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      tick();
      rst = 1'b0;
      cyc = 1;
      clear_logs();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      id_params_t p0;
      int n0;
      // reset release with zero-wait memory
      do_reset();
      run(8);
      chk("first_cyc0", 64'(acc_cyc[0]), 64'd1);
      chk("first_cyc1", 64'(acc_cyc[1]), 64'd3);
      chk("first_cyc2", 64'(acc_cyc[2]), 64'd5);
      chk("first_addr2", 64'(acc_addr[2]), 64'd8);
      chk("first_ia0", 64'(hs_log[0].ia_plus_4), 64'd4);
      chk("first_ia1", 64'(hs_log[1].ia_plus_4), 64'd8);
      chk("first_ia2", 64'(hs_log[2].ia_plus_4), 64'd12);
      // back-pressure from ID
      n = 0;
      while (!id_valid && n < 20) begin tick(); n++; end
      chk("wait_id_valid", 64'(n < 20), 64'd1);
      id_ready = 1'b0;
      p0 = id_params;
      n0 = acc_addr.size();
      run(5);
      chk("stall_params", id_params, p0);
      chk("stall_valid", 64'(id_valid), 64'd1);
      chk("stall_no_req", 64'(acc_addr.size()), 64'(n0));
      id_ready = 1'b1;
      run(6);
      chk("stall_resume", 64'(acc_addr.size() > n0), 64'd1);
      // redirect while a request is outstanding
      lat = 2;
      n = 0;
      while (!(mem_pend && mem_wait > 0) && n < 20) begin tick(); n++; end
      chk("wait_pend", 64'(n < 20), 64'd1);
      redirect = 1'b1;
      redirect_addr = 32'h0000_1003;
      tick();
      redirect = 1'b0;
      lat = 0;
      clear_logs();
      run(12);
      chk("redir_addr", 64'(acc_addr[0]), 64'h1000);
      chk("redir_ir", 64'(hs_log[0].ir), 64'(mem_fn(32'h1000)));
      // redirect in the same cycle as a response
      n = 0;
      while (!imem_rsp_valid && n < 20) begin tick(); n++; end
      chk("wait_rsp", 64'(n < 20), 64'd1);
      redirect = 1'b1;
      redirect_addr = 32'h0000_2000;
      tick();
      redirect = 1'b0;
      clear_logs();
      run(10);
      chk("coinc_addr", 64'(acc_addr[0]), 64'h2000);
      chk("coinc_first", hs_log[0], {mem_fn(32'h2000), 32'h2004});
      // PC wrap at the top of the address space
      redirect = 1'b1;
      redirect_addr = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      clear_logs();
      run(10);
      chk("wrap_addr0", 64'(acc_addr[0]), 64'hFFFF_FFFC);
      chk("wrap_addr1", 64'(acc_addr[1]), 64'h0);
      chk("wrap_ia", 64'(hs_log[0].ia_plus_4), 64'h0);
      // asynchronous reset while waiting on memory
      lat = 5;
      n = 0;
      while (!mem_pend && n < 20) begin tick(); n++; end
      chk("wait_pend2", 64'(n < 20), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_id_valid", 64'(id_valid), 64'd0);
      chk("async_id_params", id_params, 64'd0);
      chk("async_req_valid", 64'(imem_req_valid), 64'd0);
      do_reset();
      lat = 0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = 32'hDEAD_BEEF;
      run(8);
      chk("rst2_cyc", 64'(acc_cyc[0]), 64'd1);
      chk("rst2_addr", 64'(acc_addr[0]), 64'(RESET_VECTOR));
      chk("rst2_first", hs_log[0], {mem_fn(RESET_VECTOR), RESET_VECTOR + 32'd4});
      // randomized traffic
      lat_rand = 1'b1;
      n0 = hs;
      for (int i = 0; i < 3000; i++) begin
         imem_req_ready = $urandom_range(3, 0) != 0;
         id_ready = $urandom_range(3, 0) != 0;
         redirect = $urandom_range(15, 0) == 0;
         redirect_addr = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF0 | ($urandom() & 32'hF) : $urandom() & 32'h0000_3FFF;
         tick();
      end
      redirect = 1'b0;
      id_ready = 1'b1;
      imem_req_ready = 1'b1;
      run(10);
      chk("random_progress", 64'(hs - n0 > 200), 64'd1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
